// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter: req/done handshake, latched operands, registered EXEC stage.
// Optional round-robin arbitration when ALU_ARB_RR_EN is defined; fixed priority (req0 first) otherwise.
module alu_arbiter #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              req0,
  input  logic [2:0]        op0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              req1,
  input  logic [2:0]        op1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                win_q, win_d;
  logic                last_q, last_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt0_q, cnt0_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;
  logic                win_s;

  function automatic logic [DATA_W-1:0] alu_fn(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    case (op)
      3'd0:    r = {DATA_W{1'b0}};
      3'd1:    r = b - a;
      3'd2:    r = a - b;
      3'd3:    r = a + b;
      3'd4:    r = a ^ b;
      3'd5:    r = a | b;
      3'd6:    r = a & b;
      3'd7:    r = {DATA_W{1'b1}};
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  // Arbitration: pick the requester to serve (0 or 1) when leaving IDLE.
  always_comb begin
    win_s = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (req0 && req1) begin
      win_s = ~last_q;
    end else if (req0) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
`else
    // The pointer is tracked in both builds; fixed priority simply never consults it.
    if (req0) begin
      win_s = 1'b0 & last_q;
    end else begin
      win_s = 1'b1;
    end
`endif
  end

  // Next-state and registered-output logic for the IDLE/EXEC/DONE sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    win_d    = win_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    result_d = result_q;
    busy_d   = busy_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          win_d   = win_s;
          op_d    = win_s ? op1 : op0;
          a_d     = win_s ? a1  : a0;
          b_d     = win_s ? b1  : b0;
          gnt_d   = win_s ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        result_d = alu_fn(op_q, a_q, b_q);
        done_d   = gnt_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (win_q) begin
          cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        last_d  = win_q;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous clear; an in-flight op is dropped.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'd0;
      a_q      <= {DATA_W{1'b0}};
      b_q      <= {DATA_W{1'b0}};
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      result_q <= {DATA_W{1'b0}};
      busy_q   <= 1'b0;
      cnt0_q   <= {CNT_W{1'b0}};
      cnt1_q   <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      win_q    <= win_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign cnt0   = cnt0_q;
  assign cnt1   = cnt1_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU between two requesters using a req/done handshake.
- The ALU uses the team's standard 3-bit op encoding.
- Each request's operands are latched on grant. The operation is computed in a registered EXEC stage, and the result is returned with a one-cycle done pulse to the granted requester.
- Sits between the two datapath clients and the ALU function; it also keeps a per-requester completed-operation count.

Parameters:
- DATA_W, 4: operand/result width.
- CNT_W, 8: width of each per-requester completion counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- sclr  in  1  reset; one clock; synchronous, active-high.
- req0  in  1  requester 0 request; held high until done0.
- op0  in  3  requester 0 operation code.
- a0  in  DATA_W  requester 0 operand A.
- b0  in  DATA_W  requester 0 operand B.
- req1  in  1  requester 1 request.
- op1  in  3  requester 1 operation code.
- a1  in  DATA_W  requester 1 operand A.
- b1  in  DATA_W  requester 1 operand B.
- gnt  out  2  one-hot grant, held from grant through DONE.
- done  out  2  one-hot, one-cycle completion pulse.
- result  out  DATA_W  ALU result; valid while done != 0, holds last value otherwise.
- busy  out  1  high in EXEC and DONE.
- cnt0  out  CNT_W  operations completed for requester 0.
- cnt1  out  CNT_W  operations completed for requester 1.

Behaviour:
- Reset (sclr=1 at posedge, from any state):
  - state=IDLE; gnt=0, done=0, result=0, busy=0, cnt0=0, cnt1=0; last-served pointer=1, so requester 0 wins first.
  - An in-flight op is discarded: no done pulse, no count.
- FSM states IDLE, EXEC, DONE:
  - IDLE: no req -> stay. Any req -> select winner, latch its op/a/b, set gnt[winner], go EXEC.
  - EXEC: result <= ALU(latched op, a, b), go DONE.
  - DONE: done[winner]=1 for exactly this cycle, increment cnt of winner, update last-served pointer to winner, go IDLE. gnt clears on entry to IDLE.
- Latency: req sampled high in IDLE at edge N; gnt visible after N; done and result visible after N+1; back in IDLE after N+2. Throughput is one op per 3 cycles.
- Requester may change op/a/b or drop req after grant; the latched values are used and done still pulses.
- A req still high in IDLE after its done counts as a new request. Back-to-back clients keep req high.
- ALU, all results truncated to DATA_W bits, modulo 2^DATA_W:
  - 0 -> 0.
  - 1 -> B-A (wraps: A=3, B=1 gives 4'hE).
  - 2 -> A-B.
  - 3 -> A+B (carry dropped: 15+15 gives 4'hE).
  - 4 -> A^B.
  - 5 -> A|B.
  - 6 -> A&B.
  - 7 -> all ones.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation.
- Arbitration (default, without macro): fixed priority, requester 0 wins any simultaneous request.

Optional Feature:
- Macro: ALU_ARB_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, the requester not equal to the last-served pointer wins. A single requester always wins regardless of pointer. Pointer updates in DONE.
- Undefined: fixed priority, req0 over req1. The pointer register is still kept but ignored.

Test Plan:
- Reset then req0=1, op0=3, a0=15, b0=15 -> gnt=01 one cycle later; done=01 and result=4'hE two cycles after sampling; cnt0=1.
- req1 alone, op1=1, a1=3, b1=1 -> done=10 with result=4'hE; op1=7 gives 4'hF; op1=0 gives 0.
- Both req held high for 4 ops with ALU_ARB_RR_EN:
  - grant order 0,1,0,1; cnt0=2, cnt1=2.
  - Without the macro: grant order 0,0,0,0.
- Grant req0 with op0=6, a0=4'hC, b0=4'hA, then change a0 to 0 during EXEC -> result=4'h8 from the latched operands.
- Assert sclr during EXEC -> next cycle gnt=0, busy=0, done never pulses, result=0, counters=0; a subsequent req0 completes normally.
- Run 256 ops on requester 0 with CNT_W=8 -> cnt0 wraps to 0; cnt1 unchanged.
